// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: access owner states and return-path tags.
package dmem_arb_pkg;
  localparam int S_W = 32;
  localparam int V_W = 192;

  typedef enum logic [1:0] {IDLE, CPU, VGA} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VGA} tag_t;

  // Travels one cycle behind the RAM address to steer mem_rd to its requester.
  typedef struct packed {
    tag_t owner;
    logic last;
  } rtag_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, VGA fetcher and RAM signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int S = dmem_arb_pkg::S_W,
  parameter int V = dmem_arb_pkg::V_W
);
  logic         cpu_req;
  logic         cpu_we;
  logic [S-1:0] cpu_addr;
  logic [V-1:0] cpu_wd;
  logic         cpu_stall;
  logic         cpu_rvalid;
  logic [V-1:0] cpu_rd;
  logic         vga_req;
  logic [S-1:0] vga_base;
  logic         vga_urgent;
  logic         vga_ack;
  logic         vga_rvalid;
  logic [V-1:0] vga_rdata;
  logic         vga_done;
  logic [S-1:0] mem_addr;
  logic         mem_we;
  logic [V-1:0] mem_wd;
  logic [V-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, vga_req, vga_base, vga_urgent, mem_rd,
    output cpu_stall, cpu_rvalid, cpu_rd, vga_ack, vga_rvalid, vga_rdata, vga_done,
           mem_addr, mem_we, mem_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, vga_req, vga_base, vga_urgent, mem_rd,
    input  cpu_stall, cpu_rvalid, cpu_rd, vga_ack, vga_rvalid, vga_rdata, vga_done,
           mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter_burst_addr_gen.sv
// VGA burst address generator: beat 0 uses the base directly, later beats come from
// a latched, incrementing address that wraps modulo 2^S.
module burst_addr_gen #(
  parameter int S     = 32,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         step,
  input  logic [S-1:0] base,
  output logic [S-1:0] addr,
  output logic         last,
  output logic         busy
);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  logic [BW-1:0] beat_q;
  logic [S-1:0]  addr_q;

  assign addr = start ? base : addr_q;
  assign last = start ? 1'b0 : (beat_q == LAST_BEAT);
  // Non-zero beat count means beats of an accepted burst are still outstanding.
  assign busy = (beat_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0;
      addr_q <= '0;
    end else if (start) begin
      beat_q <= BW'(1);
      addr_q <= base + S'(1);
    end else if (step) begin
      beat_q <= last ? '0 : beat_q + BW'(1);
      addr_q <= addr_q + S'(1);
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between single-cycle CPU accesses and
// non-preemptive VGA read bursts, with a wait counter bounding VGA latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BURST    = 4,
  parameter int MAX_WAIT = 16
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  state_t        state_q, state_d;
  rtag_t         tag_q, tag_d;
  logic [WW-1:0] wait_q;
  logic          vga_win, start, step;
  logic [S_W-1:0] beat_addr;
  logic          beat_last, burst_busy;

  burst_addr_gen #(.S(S_W), .BURST(BURST)) u_gen (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .step  (step),
    .base  (bus.vga_base),
    .addr  (beat_addr),
    .last  (beat_last),
    .busy  (burst_busy)
  );

  assign vga_win = bus.vga_req && (!bus.cpu_req || bus.vga_urgent || wait_q == WAIT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Owner of this cycle's access: an unfinished burst keeps the RAM, otherwise arbitrate.
  // Grants are suppressed while reset is held so the RAM sees no stray write.
  always_comb begin
    state_d = IDLE;
    start   = 1'b0;
    if (!rst) begin
      state_d = IDLE;
    end else if (state_q == VGA && burst_busy) begin
      state_d = VGA;
    end else if (vga_win) begin
      state_d = VGA;
      start   = 1'b1;
    end else if (bus.cpu_req) begin
      state_d = CPU;
    end
  end

  assign step = (state_d == VGA) && !start;

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    bus.mem_wd   = '0;
    tag_d        = '{owner: TAG_NONE, last: 1'b0};
    case (state_d)
      CPU: begin
        bus.mem_addr = bus.cpu_addr;
        bus.mem_we   = bus.cpu_we;
        bus.mem_wd   = bus.cpu_wd;
        tag_d.owner  = bus.cpu_we ? TAG_NONE : TAG_CPU;
      end
      VGA: begin
        bus.mem_addr = beat_addr;
        tag_d.owner  = TAG_VGA;
        tag_d.last   = beat_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tag_q <= '{owner: TAG_NONE, last: 1'b0};
    else      tag_q <= tag_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      wait_q <= '0;
    else if (!bus.vga_req || start) wait_q <= '0;
    else if (wait_q != WAIT_MAX)   wait_q <= wait_q + WW'(1);
  end

  assign bus.cpu_stall  = bus.cpu_req && (state_d != CPU);
  assign bus.vga_ack    = start;
  assign bus.cpu_rvalid = (tag_q.owner == TAG_CPU);
  assign bus.cpu_rd     = bus.cpu_rvalid ? bus.mem_rd : '0;
  assign bus.vga_rvalid = (tag_q.owner == TAG_VGA);
  assign bus.vga_rdata  = bus.vga_rvalid ? bus.mem_rd : '0;
  assign bus.vga_done   = bus.vga_rvalid && tag_q.last;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read RAM.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  dmem_arbiter_if ifc ();

  dmem_arbiter #(.BURST(4), .MAX_WAIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  logic [191:0] ram [logic [31:0]];
  logic [191:0] rd_tmp;

  function automatic logic [191:0] pat(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, 128'h0, ~a};
  endfunction

  always @(posedge clk) begin
    rd_tmp = ram.exists(ifc.mem_addr) ? ram[ifc.mem_addr] : pat(ifc.mem_addr);
    ifc.mem_rd <= rd_tmp;
    if (ifc.mem_we) ram[ifc.mem_addr] = ifc.mem_wd;
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    ifc.cpu_req    = 1'b0;
    ifc.cpu_we     = 1'b0;
    ifc.cpu_addr   = '0;
    ifc.cpu_wd     = '0;
    ifc.vga_req    = 1'b0;
    ifc.vga_base   = '0;
    ifc.vga_urgent = 1'b0;
  endtask

  task automatic cpu_rd_in(input logic [31:0] a);
    ifc.cpu_req  = 1'b1;
    ifc.cpu_we   = 1'b0;
    ifc.cpu_addr = a;
    ifc.cpu_wd   = '0;
  endtask

  initial begin
    int k, grants, acks, rv, dn;
    logic found;
    idle_in();
    ifc.mem_rd = '0;

    // Reset held: combinational outputs forced quiet, stall follows cpu_req.
    #2 ifc.cpu_req = 1'b1;
    #1;
    chk("rst_stall", ifc.cpu_stall, 1);
    chk("rst_ack", ifc.vga_ack, 0);
    chk("rst_we", ifc.mem_we, 0);
    chk("rst_cpu_rvalid", ifc.cpu_rvalid, 0);
    chk("rst_vga_rvalid", ifc.vga_rvalid, 0);
    chk("rst_done", ifc.vga_done, 0);
    chk("rst_cpu_rd", ifc.cpu_rd, 0);
    ifc.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // CPU write then read.
    @(negedge clk);
    ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1; ifc.cpu_addr = 32'h10; ifc.cpu_wd = 192'hABC;
    #1;
    chk("wr_we", ifc.mem_we, 1);
    chk("wr_addr", ifc.mem_addr, 32'h10);
    chk("wr_wd", ifc.mem_wd, 192'hABC);
    chk("wr_stall", ifc.cpu_stall, 0);
    @(negedge clk);
    cpu_rd_in(32'h10);
    #1;
    chk("rd_we", ifc.mem_we, 0);
    chk("rd_stall", ifc.cpu_stall, 0);
    chk("wr_no_rvalid", ifc.cpu_rvalid, 0);
    @(negedge clk);
    idle_in();
    #1;
    chk("rd_rvalid", ifc.cpu_rvalid, 1);
    chk("rd_data", ifc.cpu_rd, 192'hABC);
    chk("idle_addr", ifc.mem_addr, 0);
    @(negedge clk);
    #1;
    chk("rd_rvalid_gone", ifc.cpu_rvalid, 0);

    // Idle VGA burst from 0x64; base changes after ack must not matter.
    @(negedge clk);
    ifc.vga_req = 1'b1; ifc.vga_base = 32'h64;
    #1;
    chk("b_ack", ifc.vga_ack, 1);
    chk("b_addr0", ifc.mem_addr, 32'h64);
    chk("b_we", ifc.mem_we, 0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      ifc.vga_req = 1'b0; ifc.vga_base = 32'hDEAD;
      #1;
      if (j < 4) chk($sformatf("b_addr%0d", j), ifc.mem_addr, 32'h64 + j);
      chk($sformatf("b_rvalid%0d", j), ifc.vga_rvalid, 1);
      chk($sformatf("b_rdata%0d", j), ifc.vga_rdata, pat(32'h64 + j - 1));
      chk($sformatf("b_done%0d", j), ifc.vga_done, (j == 4));
    end
    @(negedge clk);
    idle_in();
    #1;
    chk("b_rvalid_end", ifc.vga_rvalid, 0);

    // Contention: CPU holds the RAM for MAX_WAIT cycles, then VGA overrides.
    found = 1'b0; grants = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      cpu_rd_in(32'h20);
      ifc.vga_req = 1'b1; ifc.vga_base = 32'h200;
      #1;
      if (ifc.vga_ack) begin found = 1'b1; break; end
      if (!ifc.cpu_stall) grants++;
    end
    chk("c_ack_at", k, 16);
    chk("c_cpu_grants", grants, 16);
    chk("c_stall_ack", ifc.cpu_stall, 1);
    chk("c_addr0", ifc.mem_addr, 32'h200);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      ifc.vga_req = 1'b0;
      #1;
      chk($sformatf("c_stall%0d", j), ifc.cpu_stall, 1);
      chk($sformatf("c_addr%0d", j), ifc.mem_addr, 32'h200 + j);
    end
    @(negedge clk);
    #1;
    chk("c_stall_release", ifc.cpu_stall, 0);
    chk("c_done", ifc.vga_done, 1);

    // Request withdrawn before ack clears the wait count.
    acks = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      ifc.vga_req = 1'b1; ifc.vga_base = 32'h280;
      #1;
      if (ifc.vga_ack) acks++;
    end
    chk("w_no_ack", acks, 0);
    @(negedge clk);
    ifc.vga_req = 1'b0;
    found = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      ifc.vga_req = 1'b1;
      #1;
      if (ifc.vga_ack) begin found = 1'b1; break; end
    end
    chk("w_ack_after_clear", k, 16);
    @(negedge clk);
    idle_in();
    repeat (5) @(negedge clk);

    // Urgent override in the very first cycle of contention.
    @(negedge clk);
    cpu_rd_in(32'h30);
    ifc.vga_req = 1'b1; ifc.vga_urgent = 1'b1; ifc.vga_base = 32'h300;
    #1;
    chk("u_ack", ifc.vga_ack, 1);
    chk("u_stall", ifc.cpu_stall, 1);
    chk("u_addr", ifc.mem_addr, 32'h300);
    @(negedge clk);
    idle_in();
    repeat (5) @(negedge clk);

    // Address wrap at the top of the address space.
    @(negedge clk);
    ifc.vga_req = 1'b1; ifc.vga_base = 32'hFFFF_FFFE;
    #1;
    chk("wr_ack", ifc.vga_ack, 1);
    chk("wrap_a0", ifc.mem_addr, 32'hFFFF_FFFE);
    @(negedge clk);
    idle_in();
    #1;
    chk("wrap_a1", ifc.mem_addr, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    chk("wrap_a2", ifc.mem_addr, 32'h0);
    @(negedge clk);
    #1;
    chk("wrap_a3", ifc.mem_addr, 32'h1);
    @(negedge clk);
    #1;
    chk("wrap_done", ifc.vga_done, 1);
    chk("wrap_data", ifc.vga_rdata, pat(32'h1));
    repeat (2) @(negedge clk);

    // Reset during beat 2 abandons the burst.
    @(negedge clk);
    ifc.vga_req = 1'b1; ifc.vga_base = 32'h400;
    #1;
    chk("r_ack", ifc.vga_ack, 1);
    @(negedge clk);
    ifc.vga_req = 1'b0;
    @(negedge clk);
    #1;
    chk("r_rvalid_pre", ifc.vga_rvalid, 1);
    rst = 1'b0;
    #1;
    chk("r_rvalid", ifc.vga_rvalid, 0);
    chk("r_rdata", ifc.vga_rdata, 0);
    chk("r_done", ifc.vga_done, 0);
    chk("r_we", ifc.mem_we, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rv = 0; dn = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      #1;
      if (ifc.vga_rvalid) rv++;
      if (ifc.vga_done) dn++;
    end
    chk("r_no_rvalid", rv, 0);
    chk("r_no_done", dn, 0);

    @(negedge clk);
    ifc.vga_req = 1'b1; ifc.vga_base = 32'h500;
    #1;
    chk("r2_ack", ifc.vga_ack, 1);
    rv = 0; dn = 0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      ifc.vga_req = 1'b0;
      #1;
      if (ifc.vga_rvalid) rv++;
      if (ifc.vga_done) begin
        dn++;
        chk("r2_done_at", j, 4);
        chk("r2_last_data", ifc.vga_rdata, pat(32'h503));
      end
    end
    chk("r2_rvalids", rv, 4);
    chk("r2_dones", dn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port, synchronous-read data memory between the CPU memory stage and a VGA scan-out line fetcher. CPU accesses are single-cycle with a stall handshake. VGA fetches are fixed-length read bursts. A wait counter and an urgency input bound VGA latency so the display never starves. The block sits between the memory-stage pipeline register, the pixel fetcher and the data RAM.

## Interface
- S, 32, address/scalar width
- V, 192, data word width
- BURST, 4, VGA beats per burst (≥2)
- MAX_WAIT, 16, cycles a pending VGA request may wait before it overrides the CPU
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access requested this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  S  CPU word address
- cpu_wd  in  V  CPU write data
- cpu_stall  out  1  comb: cpu_req && CPU not granted this cycle
- cpu_rvalid  out  1  read data valid (one cycle after a granted read)
- cpu_rd  out  V  read data, meaningful when cpu_rvalid
- vga_req  in  1  burst request, held until acked
- vga_base  in  S  burst start address, sampled at ack
- vga_urgent  in  1  fetcher buffer below low-water mark
- vga_ack  out  1  one-cycle pulse: burst accepted, beat 0 issued this cycle
- vga_rvalid  out  1  burst data beat valid
- vga_rdata  out  V  burst beat data
- vga_done  out  1  pulses together with the last vga_rvalid
- mem_addr  out  S  RAM address
- mem_we  out  1  RAM write enable
- mem_wd  out  V  RAM write data
- mem_rd  in  V  RAM read data, valid the cycle after its address

## Operation
- States: IDLE, CPU, VGA. The state holds the owner of the current cycle's RAM access.
- Decision, made in IDLE, CPU, and on the last VGA beat:
  - VGA wins if vga_req && (!cpu_req || vga_urgent || wait_cnt == MAX_WAIT).
  - Otherwise CPU wins if cpu_req.
  - Otherwise IDLE.
- CPU grant: for exactly one cycle, mem_addr = cpu_addr, mem_we = cpu_we, mem_wd = cpu_wd. Back-to-back CPU grants are allowed.
- VGA grant:
  - vga_base is latched into beat_addr; vga_ack pulses.
  - Beats 0..BURST-1 issue reads at base, base+1, … on consecutive cycles. Address arithmetic wraps modulo 2^S.
  - A burst is non-preemptive. cpu_stall stays high for its whole duration.
- Return tagging: a one-cycle registered tag (NONE/CPU/VGA, plus a last flag) routes mem_rd on the next cycle.
  - CPU tag on a read → cpu_rvalid = 1, cpu_rd = mem_rd.
  - VGA tag → vga_rvalid = 1, vga_rdata = mem_rd; vga_done = 1 when the last flag is set.
  - Writes produce no rvalid.
- wait_cnt:
  - Cleared on vga_ack or when !vga_req.
  - Otherwise increments each cycle vga_req is pending and unacked, saturating at MAX_WAIT.
- mem_we is 0 in every non-CPU-write cycle. mem_addr/mem_wd are don't-care when idle and driven 0 in that case.

## Timing
- Reset (async assert, sync release): state = IDLE, wait_cnt = 0, tag = NONE, beat = 0. All registered outputs are 0 (cpu_rvalid, vga_rvalid, vga_done, cpu_rd, vga_rdata).
- Combinational outputs while reset is held: vga_ack = 0, mem_we = 0, cpu_stall = cpu_req.
- CPU read latency: grant at cycle N, cpu_rvalid at N+1.
- VGA burst:
  - ack at N, rvalid at N+1 … N+BURST, done at N+BURST.
  - The next grant may issue at N+BURST, overlapping the last return.
- Simultaneous CPU and VGA requests with wait_cnt < MAX_WAIT and !vga_urgent: CPU is granted and wait_cnt increments.
- Continuous cpu_req: VGA is granted no later than MAX_WAIT cycles after vga_req rises.
- vga_req dropped before ack: no burst is issued and wait_cnt clears.
- Reset mid-burst: the burst is abandoned. No further rvalid and no vga_done; the fetcher must re-request.

## Structure
- Package dmem_arb_pkg: state enum {IDLE, CPU, VGA}, owner tag enum {TAG_NONE, TAG_CPU, TAG_VGA}.
- One sub-module, burst_addr_gen: latches the base on start, steps the beat counter and address, and flags the last beat.

## Test plan
- **CPU write then read:** write addr 0x10 = 0xABC, then read 0x10 → mem_we=1 in the write cycle; cpu_rvalid one cycle after the read grant with cpu_rd=0xABC; cpu_stall=0 throughout.
- **Idle VGA burst:** vga_req with base 0x64 and BURST=4 → ack at N; mem_addr 0x64..0x67 at N..N+3; 4 rvalids at N+1..N+4; done at N+4.
- **Contention:** cpu_req held high, vga_req rises at T, MAX_WAIT=16, urgent=0 → CPU granted for 16 cycles, vga_ack at T+16, cpu_stall high for BURST cycles.
- **Urgent override:** cpu_req and vga_req rise together with vga_urgent=1 → VGA ack in the same cycle, cpu_stall=1.
- **Wrap:** base 0xFFFF_FFFE → addresses FFFF_FFFE, FFFF_FFFF, 0, 1.
- **Reset mid-burst:** rst low during beat 2 → all outputs 0 immediately, no vga_done; a new request after release completes a full burst.
